seq_adder_nbits: RTL and testbench

- Parametrised multi-cycle ripple adder/subtractor; successor to the 4-bit combinational adder.
- Processes a WIDTH-bit operand pair one CHUNK-bit slice per clock, propagating carry between slices in a register.
- Adds a start/busy/done handshake, a subtract mode and a signed-overflow flag.
- Sits in the ALU datapath, where wide operands must not create a long combinational carry chain.

---
 rtl/seq_adder_nbits.sv | 188 ++++++++++++++++++
 tb/tb_seq_adder_nbits.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_nbits.sv
// ---------------------------------------------------------------------------
// seq_adder_nbits
//
// Multi-cycle ripple adder/subtractor. A WIDTH-bit operand pair is processed
// one CHUNK-bit slice per clock (LSB slice first). The carry between slices
// is held in a register, so the longest combinational carry chain is only
// CHUNK bits regardless of WIDTH.
//
// Subtract mode computes a - b - ci (6502-style borrow): the adder is fed
// ~b and ~ci, so co=1 in subtract mode means "no borrow".
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request; sampled only in IDLE
//   sub    in   0 = add, 1 = subtract; latched with the operands
//   a, b   in   WIDTH-bit operands; latched when start is accepted
//   ci     in   carry-in (add) / borrow-in (sub); latched with the operands
//   busy   out  high while slices are being processed (RUN)
//   done   out  one-cycle pulse; s/co/ov valid
//   s      out  WIDTH-bit sum/difference
//   co     out  carry-out of the MSB slice
//   ov     out  two's-complement overflow
//
// Timing: accept edge E0, slices computed at edges E1..EN (N = WIDTH/CHUNK),
// done high in the cycle after EN. One operation per N+2 cycles.
// s/co/ov only change on entry to DONE (or on reset).
// ---------------------------------------------------------------------------

// One CHUNK-bit ripple slice: {c_o, s_o} = a_i + b_i + c_i.
module seq_adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o
);
    logic [CHUNK:0] sum;

    assign sum        = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
    assign {c_o, s_o} = sum;
endmodule

module seq_adder_nbits #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    // Elaboration-time parameter sanity checks.
    if (CHUNK < 1) begin : g_chk_chunk
        $error("seq_adder_nbits: CHUNK must be >= 1");
    end
    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_chk_width
        $error("seq_adder_nbits: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q,     a_d;
    logic [WIDTH-1:0]  bx_q,    bx_d;     // effective B' (b or ~b)
    logic [WIDTH-1:0]  acc_q,   acc_d;
    logic [WIDTH-1:0]  s_q,     s_d;
    logic              co_q,    co_d;
    logic              ov_q,    ov_d;

    // Current slice operands, selected by the slice index.
    int                base;
    logic [CHUNK-1:0]  sl_a;
    logic [CHUNK-1:0]  sl_b;
    logic [CHUNK-1:0]  sl_sum;
    logic              sl_co;

    always_comb begin
        base = int'(idx_q) * CHUNK;
        sl_a = a_q[base +: CHUNK];
        sl_b = bx_q[base +: CHUNK];
    end

    seq_adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a_i (sl_a),
        .b_i (sl_b),
        .c_i (carry_q),
        .s_o (sl_sum),
        .c_o (sl_co)
    );

    // Next-state / datapath
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        bx_d    = bx_q;
        acc_d   = acc_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    // Subtraction is a + ~b + ~ci, giving a - b - ci.
                    bx_d    = sub ? ~b  : b;
                    carry_d = sub ? ~ci : ci;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[base +: CHUNK] = sl_sum;
                carry_d              = sl_co;
                if (idx_q == LAST) begin
                    // acc_d already holds the final slice here.
                    s_d     = acc_d;
                    co_d    = sl_co;
                    ov_d    = (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                              (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            bx_q    <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;
    assign ov   = ov_q;
endmodule

// File: tb/tb_seq_adder_nbits.sv
// ---------------------------------------------------------------------------
// Testbench for seq_adder_nbits. Two instances: 16/4 (N=4) as the main
// target and 4/4 (N=1) for the degenerate single-slice case. Results are
// checked against a whole-word arithmetic model (integer add/subtract and a
// signed-range overflow test).
// ---------------------------------------------------------------------------
module tb_seq_adder_nbits;
    localparam int W  = 16;
    localparam int C  = 4;
    localparam int N  = W / C;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, sub, ci;
    logic [W-1:0]  a, b;
    logic          busy, done, co, ov;
    logic [W-1:0]  s;

    logic          start4, sub4, ci4;
    logic [3:0]    a4, b4;
    logic          busy4, done4, co4, ov4;
    logic [3:0]    s4;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected s/co/ov of the most recent completed operation.
    logic [W-1:0]  prev_s;
    logic          prev_co, prev_ov;

    always #5 clk = ~clk;

    seq_adder_nbits #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co), .ov(ov)
    );

    seq_adder_nbits #(.WIDTH(4), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .ci(ci4),
        .busy(busy4), .done(done4), .s(s4), .co(co4), .ov(ov4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {ov, co, s} for a WIDTH=16 operation.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic msub, input logic mci);
        int ur, sr, sa, sb;
        logic [17:0] r;
        sa = $signed(ma);
        sb = $signed(mb);
        if (!msub) begin
            ur = int'(ma) + int'(mb) + int'(mci);
            sr = sa + sb + int'(mci);
        end else begin
            // +65536 keeps ur non-negative; bit 16 set means no borrow.
            ur = int'(ma) - int'(mb) - int'(mci) + 65536;
            sr = sa - sb - int'(mci);
        end
        r[15:0] = ur[15:0];
        r[16]   = ur[16];
        r[17]   = (sr > 32767) || (sr < -32768);
        return r;
    endfunction

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                         input logic tc, input bit hold);
        logic [17:0] m;
        int lat, nb;
        bit got;
        m = model(ta, tb_, ts, tc);
        @(negedge clk);
        a = ta; b = tb_; sub = ts; ci = tc; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        // Operands may change after acceptance without effect.
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); ci = 1'($urandom);
        lat = 0; nb = 0; got = 0;
        while (lat < 20) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) nb++;
            chk("hold_s",  s,  prev_s);
            chk("hold_co", co, prev_co);
            chk("hold_ov", ov, prev_ov);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("timeout",      got,  1);
        chk("latency",      lat,  N);
        chk("busy_cycles",  nb,   N);
        chk("busy_in_done", busy, 0);
        chk("s",  s,  m[15:0]);
        chk("co", co, m[16]);
        chk("ov", ov, m[17]);
        prev_s = m[15:0]; prev_co = m[16]; prev_ov = m[17];
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
    endtask

    task automatic do_op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                          input logic [3:0] es, input logic eco);
        int lat;
        @(negedge clk);
        a4 = ta; b4 = tb_; ci4 = tc; sub4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        chk("w4_busy", busy4, 1);
        while (!done4 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w4_latency", lat, 1);
        chk("w4_s",  s4,  es);
        chk("w4_co", co4, eco);
        @(posedge clk); #1;
        chk("w4_done_pulse", done4, 0);
    endtask

    initial begin
        int dcount;
        rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        start4 = 1'b0; sub4 = 1'b0; ci4 = 1'b0; a4 = '0; b4 = '0;
        prev_s = '0; prev_co = 1'b0; prev_ov = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s",    s,    0);
        chk("rst_co",   co,   0);
        chk("rst_ov",   ov,   0);
        rst = 1'b0;

        // Degenerate single-slice instance
        do_op4(4'h1, 4'h2, 1'b0, 4'h3, 1'b0);
        do_op4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
        do_op4(4'hF, 4'h1, 1'b1, 4'h1, 1'b1);

        // Directed 16-bit cases
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        // start held high through RUN
        do_op(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1);

        // Reset in the second RUN cycle aborts the operation
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; sub = 1'b0; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_s",    s,    0);
        chk("abort_co",   co,   0);
        chk("abort_ov",   ov,   0);
        prev_s = '0; prev_co = 1'b0; prev_ov = 1'b0;
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        do_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
